cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Parametrised common-data-bus arbiter for the superscalar back end.
- Collects completed results from NUM_SRC functional-unit channels and grants up to NUM_CDB of them per cycle with round-robin fairness.
- Broadcasts granted results on NUM_CDB registered CDB ports to reservation stations and the ROB.
- Successor to the single-bus IQ-to-CDB path: generalised in source count, bus count and widths, and adds backpressure and flush.

Parameters:
- NUM_SRC, 4, number of functional-unit source channels (>=2)
- NUM_CDB, 2, number of CDB broadcast ports per cycle (1..NUM_SRC)
- TAG_W, 5, ROB tag width
- DATA_W, 32, result data width
- SRC_IDX_W (localparam), $clog2(NUM_SRC), source index width

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- flush_in  input  1  mispredict flush; kills this cycle's grants and clears outputs
- src_valid_in  input  NUM_SRC  per-source result valid
- src_tag_in  input  NUM_SRC*TAG_W  per-source ROB tag; source i occupies bits [i*TAG_W +: TAG_W]
- src_data_in  input  NUM_SRC*DATA_W  per-source result, same packing as src_tag_in
- src_ready_out  output  NUM_SRC  grant/accept, combinational
- cdb_valid_out  output  NUM_CDB  broadcast valid per port
- cdb_tag_out  output  NUM_CDB*TAG_W  broadcast tag per port
- cdb_data_out  output  NUM_CDB*DATA_W  broadcast data per port
- cdb_src_out  output  NUM_CDB*SRC_IDX_W  index of the source driving each port

Behaviour:
- Clock and reset: one clock (clk_in); reset rst_in is synchronous, active-high.
- Reset: all cdb_*_out = 0, round-robin pointer ptr = 0. src_ready_out is combinational and all-0 while rst_in = 1.
- Handshake:
  - Transfer occurs when src_valid_in[i] & src_ready_out[i] in the same cycle.
  - A source holds valid, tag and data stable until it is accepted.
  - A source may not drop valid before acceptance, except on flush.
- Grant selection (combinational):
  - Scan sources ptr, ptr+1, ..., ptr+NUM_SRC-1, with modulo-NUM_SRC wrap.
  - The first NUM_CDB valid sources found are granted.
  - The k-th granted source in scan order is assigned to CDB slot k.
  - src_ready_out[i] = 1 only for granted sources.
  - src_ready_out must not depend on src_ready_out (no loops).
- Broadcast latency is 1 cycle. On the clock edge after a grant, slot k registers valid = 1 plus the tag, data and source index of its granted source. Unassigned slots register valid = 0 with tag, data and src = 0.
- Pointer update:
  - If any grant occurs, ptr <= (index of last granted source + 1) mod NUM_SRC.
  - Otherwise ptr is held.
- Fewer requesters than NUM_CDB: all requesters are granted, in slots 0..n-1. Higher slots are invalid.
- No requesters: all cdb_valid_out are 0 next cycle and ptr is unchanged.
- Flush:
  - While flush_in = 1, src_ready_out = 0 for all sources and there are no grants.
  - Next cycle all cdb_valid_out = 0, and tag, data and src = 0.
  - ptr is unchanged.
  - A broadcast already registered before the flush cycle is still visible during the flush cycle.
- Reset mid-operation: the same cycle forces ready to 0. The next edge clears outputs and sets ptr = 0. Pending source requests are simply re-arbitrated after reset.
- A tag/data value equal on two sources is not checked; both are broadcast if granted.

Optional Feature:
- Macro: CDB_STALL_STATS_EN.
- When defined, the block adds output stall_cnt_out (32 bits).
  - Each cycle, stall_cnt_out increments by the number of sources with src_valid_in = 1 and src_ready_out = 0.
  - Flush cycles are excluded from counting.
  - The counter saturates at 32'hFFFF_FFFF.
  - It resets to 0 on rst_in.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan (NUM_SRC = 4, NUM_CDB = 2, TAG_W = 5, DATA_W = 32):
- Reset, then src_valid = 4'b0001, tag 3, data 0x11 -> ready = 0001 same cycle. Next cycle: slot0 valid, tag 3, data 0x11, src 0. slot1 invalid. ptr = 1.
- From ptr = 0, valid = 1111 held for 2 cycles:
  - Cycle 1: grants 0, 1 (slots 0, 1), ptr -> 2.
  - Cycle 2: grants 2, 3, ptr -> 0.
  - Broadcasts appear one cycle after each grant.
- Wrap: ptr = 3, valid = 1001 -> slot0 = src 3, slot1 = src 0, ptr -> 1.
- Flush with valid = 1111 -> ready = 0000. Next cycle all cdb_valid = 0 and ptr unchanged. The following cycle grants resume from the same ptr.
- No requests for 3 cycles -> cdb_valid = 00 each cycle and ptr stable. Assert rst_in mid-stream with valid = 0110 -> ready = 0 that cycle, then outputs 0 and ptr = 0.
- CDB_STALL_STATS_EN defined, valid = 1111 for 2 cycles -> stall_cnt_out = 2 after cycle 1 and 4 after cycle 2. A flush cycle adds 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus arbiter. Accepts completed results from
// NUM_SRC functional-unit channels, grants up to NUM_CDB per cycle in
// round-robin order starting at ptr, and broadcasts the granted results
// on NUM_CDB registered CDB slots one cycle later.
//
// Ports:
//   clk_in         system clock
//   rst_in         synchronous active-high reset
//   flush_in       mispredict flush: no grants this cycle, outputs cleared next
//   src_valid_in   per-source result valid
//   src_tag_in     per-source ROB tag, source i at [i*TAG_W +: TAG_W]
//   src_data_in    per-source result, source i at [i*DATA_W +: DATA_W]
//   src_ready_out  per-source grant/accept (combinational)
//   cdb_valid_out  per-slot broadcast valid
//   cdb_tag_out    per-slot broadcast tag
//   cdb_data_out   per-slot broadcast data
//   cdb_src_out    per-slot index of the source that drove it
//   stall_cnt_out  (only with CDB_STALL_STATS_EN) saturating count of
//                  valid-but-not-ready source cycles, flush cycles excluded
//
// Optional feature macro: CDB_STALL_STATS_EN
module cdb_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int NUM_CDB = 2,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32,
  localparam int SRC_IDX_W = $clog2(NUM_SRC)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          flush_in,
  input  logic [NUM_SRC-1:0]            src_valid_in,
  input  logic [NUM_SRC*TAG_W-1:0]      src_tag_in,
  input  logic [NUM_SRC*DATA_W-1:0]     src_data_in,
  output logic [NUM_SRC-1:0]            src_ready_out,
  output logic [NUM_CDB-1:0]            cdb_valid_out,
  output logic [NUM_CDB*TAG_W-1:0]      cdb_tag_out,
  output logic [NUM_CDB*DATA_W-1:0]     cdb_data_out,
  output logic [NUM_CDB*SRC_IDX_W-1:0]  cdb_src_out
`ifdef CDB_STALL_STATS_EN
  ,
  output logic [31:0]                   stall_cnt_out
`endif
);

  logic [SRC_IDX_W-1:0]   ptr;
  logic [SRC_IDX_W-1:0]   next_ptr;
  logic [NUM_SRC-1:0]     grant;
  logic [2*NUM_SRC-1:0]   valid_dbl;
  logic [NUM_SRC-1:0]     rot_valid;
  logic [NUM_CDB-1:0]     slot_vld;
  logic [SRC_IDX_W-1:0]   slot_src  [NUM_CDB];
  logic [TAG_W-1:0]       slot_tag  [NUM_CDB];
  logic [DATA_W-1:0]      slot_data [NUM_CDB];
  int unsigned            n_grant;
  int unsigned            src_idx;

  // Rotating the doubled valid vector by ptr turns the round-robin scan into
  // a fixed-order scan from bit 0; src_idx recovers the real source index.
  always_comb begin
    grant     = '0;
    slot_vld  = '0;
    next_ptr  = ptr;
    n_grant   = 0;
    src_idx   = 0;
    valid_dbl = {src_valid_in, src_valid_in};
    rot_valid = NUM_SRC'(valid_dbl >> ptr);
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      slot_src[k]  = '0;
      slot_tag[k]  = '0;
      slot_data[k] = '0;
    end
    if (!rst_in && !flush_in) begin
      for (int unsigned off = 0; off < NUM_SRC; off++) begin
        if (rot_valid[off] && (n_grant < NUM_CDB)) begin
          src_idx = (32'(ptr) + off) % NUM_SRC;
          grant   = grant | (NUM_SRC'(1) << src_idx);
          for (int unsigned k = 0; k < NUM_CDB; k++) begin
            if (k == n_grant) begin
              slot_vld[k]  = 1'b1;
              slot_src[k]  = SRC_IDX_W'(src_idx);
              slot_tag[k]  = src_tag_in[src_idx*TAG_W +: TAG_W];
              slot_data[k] = src_data_in[src_idx*DATA_W +: DATA_W];
            end
          end
          next_ptr = SRC_IDX_W'((src_idx + 1) % NUM_SRC);
          n_grant  = n_grant + 1;
        end
      end
    end
  end

  assign src_ready_out = grant;

  // Flush needs no separate branch: with no grants every slot registers zero
  // and next_ptr holds ptr.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_valid_out <= '0;
      cdb_tag_out   <= '0;
      cdb_data_out  <= '0;
      cdb_src_out   <= '0;
      ptr           <= '0;
    end else begin
      cdb_valid_out <= slot_vld;
      for (int unsigned k = 0; k < NUM_CDB; k++) begin
        cdb_tag_out[k*TAG_W +: TAG_W]           <= slot_tag[k];
        cdb_data_out[k*DATA_W +: DATA_W]        <= slot_data[k];
        cdb_src_out[k*SRC_IDX_W +: SRC_IDX_W]   <= slot_src[k];
      end
      ptr <= next_ptr;
    end
  end

`ifdef CDB_STALL_STATS_EN
  logic [32:0] stall_sum;

  always_comb begin
    stall_sum = {1'b0, stall_cnt_out} + 33'($countones(src_valid_in & ~grant));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stall_cnt_out <= '0;
    end else if (!flush_in) begin
      stall_cnt_out <= stall_sum[32] ? '1 : stall_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter (NUM_SRC=4, NUM_CDB=2, TAG_W=5,
// DATA_W=32). Reference model: scan list of valid sources in rotation order,
// first NUM_CDB entries are granted and become the next cycle's broadcast.
module tb_cdb_arbiter;
  localparam int NS = 4;
  localparam int NC = 2;
  localparam int TW = 5;
  localparam int DW = 32;
  localparam int SW = 2;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [NS-1:0]     src_valid;
  logic [NS*TW-1:0]  src_tag;
  logic [NS*DW-1:0]  src_data;
  logic [NS-1:0]     src_ready;
  logic [NC-1:0]     cdb_valid;
  logic [NC*TW-1:0]  cdb_tag;
  logic [NC*DW-1:0]  cdb_data;
  logic [NC*SW-1:0]  cdb_src;
`ifdef CDB_STALL_STATS_EN
  logic [31:0]       stall_cnt;
`endif

  cdb_arbiter #(.NUM_SRC(NS), .NUM_CDB(NC), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .flush_in      (flush),
    .src_valid_in  (src_valid),
    .src_tag_in    (src_tag),
    .src_data_in   (src_data),
    .src_ready_out (src_ready),
    .cdb_valid_out (cdb_valid),
    .cdb_tag_out   (cdb_tag),
    .cdb_data_out  (cdb_data),
    .cdb_src_out   (cdb_src)
`ifdef CDB_STALL_STATS_EN
    ,
    .stall_cnt_out (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [TW-1:0]    tags [NS];
  logic [DW-1:0]    dat  [NS];
  logic [NS-1:0]    cur_v;
  logic             cur_fl;
  logic             cur_rs;

  // model state
  int unsigned      m_ptr;
  int unsigned      m_gnt[$];
  logic [NS-1:0]    m_ready;
  logic [NC-1:0]    e_valid;
  logic [NC*TW-1:0] e_tag;
  logic [NC*DW-1:0] e_data;
  logic [NC*SW-1:0] e_src;
  longint unsigned  e_stall;

  task automatic model_select();
    m_gnt.delete();
    m_ready = '0;
    if (!cur_fl && !cur_rs) begin
      for (int off = 0; off < NS; off++) begin
        int unsigned idx;
        idx = (m_ptr + off) % NS;
        if (cur_v[idx] && m_gnt.size() < NC) begin
          m_gnt.push_back(idx);
          m_ready[idx] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_commit();
    e_valid = '0; e_tag = '0; e_data = '0; e_src = '0;
    if (cur_rs) begin
      m_ptr = 0;
      e_stall = 0;
    end else begin
      for (int k = 0; k < m_gnt.size(); k++) begin
        e_valid[k] = 1'b1;
        e_tag[k*TW +: TW] = tags[m_gnt[k]];
        e_data[k*DW +: DW] = dat[m_gnt[k]];
        e_src[k*SW +: SW] = SW'(m_gnt[k]);
      end
      if (m_gnt.size() > 0) m_ptr = (m_gnt[m_gnt.size()-1] + 1) % NS;
      if (!cur_fl) begin
        for (int i = 0; i < NS; i++)
          if (cur_v[i] && !m_ready[i]) e_stall++;
        if (e_stall > 64'hFFFF_FFFF) e_stall = 64'hFFFF_FFFF;
      end
    end
  endtask

  task automatic step(input logic [NS-1:0] v, input logic fl, input logic rs);
    cur_v = v; cur_fl = fl; cur_rs = rs;
    for (int i = 0; i < NS; i++) begin
      src_tag[i*TW +: TW]  = tags[i];
      src_data[i*DW +: DW] = dat[i];
    end
    src_valid = v; flush = fl; rst = rs;
    model_select();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < NS; i++) begin tags[i] = TW'($urandom); dat[i] = $urandom; end
    step(4'b0110, 1'b0, 1'b1);
    checks++;
    if (src_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", src_ready); end
    tick();
    step(4'b0000, 1'b0, 1'b1);
    tick();
    checks++;
    if ({cdb_valid, cdb_src, cdb_tag, cdb_data} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {cdb_valid, cdb_src, cdb_tag, cdb_data});
    end
    checks++;
    if (dut.ptr !== 2'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr); end
  endtask

  task automatic test_single();
    tags[0] = 5'd3; dat[0] = 32'h11;
    step(4'b0001, 1'b0, 1'b0);
    checks++;
    if (src_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", src_ready); end
    tick();
    checks++;
    if (cdb_valid !== 2'b01 || cdb_tag[4:0] !== 5'd3 || cdb_data[31:0] !== 32'h11 ||
        cdb_src[1:0] !== 2'd0 || cdb_tag[9:5] !== 5'd0 || cdb_data[63:32] !== 32'd0 || cdb_src[3:2] !== 2'd0) begin
      failures++; $display("FAIL single_bcast got v=%b t=%h d=%h s=%h exp v=01 t=003 d=0000000000000011 s=0",
                           cdb_valid, cdb_tag, cdb_data, cdb_src);
    end
    checks++;
    if (dut.ptr !== 2'd1) begin failures++; $display("FAIL single_ptr got=%0d exp=1", dut.ptr); end
    // move pointer back to 0 by granting source 3 alone
    tags[3] = TW'($urandom); dat[3] = $urandom;
    step(4'b1000, 1'b0, 1'b0);
    checks++;
    if (src_ready !== 4'b1000) begin failures++; $display("FAIL single_ready3 got=%b exp=1000", src_ready); end
    tick();
    checks++;
    if ({cdb_valid, cdb_src, cdb_tag, cdb_data} !== {e_valid, e_src, e_tag, e_data}) begin
      failures++; $display("FAIL single_bcast3 got=%h exp=%h", {cdb_valid, cdb_src, cdb_tag, cdb_data}, {e_valid, e_src, e_tag, e_data});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NS; i++) begin tags[i] = TW'($urandom); dat[i] = $urandom; end
    step(4'b1111, 1'b0, 1'b0);
    checks++;
    if (src_ready !== 4'b0011) begin failures++; $display("FAIL b2b_ready1 got=%b exp=0011", src_ready); end
    tick();
    checks++;
    if (cdb_valid !== 2'b11 || cdb_src !== 4'b0100 || {cdb_valid, cdb_src, cdb_tag, cdb_data} !== {e_valid, e_src, e_tag, e_data}) begin
      failures++; $display("FAIL b2b_bcast1 got=%h exp=%h", {cdb_valid, cdb_src, cdb_tag, cdb_data}, {e_valid, e_src, e_tag, e_data});
    end
    checks++;
    if (dut.ptr !== 2'd2) begin failures++; $display("FAIL b2b_ptr1 got=%0d exp=2", dut.ptr); end
    tags[0] = TW'($urandom); dat[0] = $urandom;
    tags[1] = TW'($urandom); dat[1] = $urandom;
    step(4'b1111, 1'b0, 1'b0);
    checks++;
    if (src_ready !== 4'b1100) begin failures++; $display("FAIL b2b_ready2 got=%b exp=1100", src_ready); end
    tick();
    checks++;
    if (cdb_src !== 4'b1110 || {cdb_valid, cdb_src, cdb_tag, cdb_data} !== {e_valid, e_src, e_tag, e_data}) begin
      failures++; $display("FAIL b2b_bcast2 got=%h exp=%h", {cdb_valid, cdb_src, cdb_tag, cdb_data}, {e_valid, e_src, e_tag, e_data});
    end
    checks++;
    if (dut.ptr !== 2'd0) begin failures++; $display("FAIL b2b_ptr2 got=%0d exp=0", dut.ptr); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < NS; i++) begin tags[i] = TW'($urandom); dat[i] = $urandom; end
    step(4'b0100, 1'b0, 1'b0);
    tick();
    checks++;
    if (dut.ptr !== 2'd3) begin failures++; $display("FAIL wrap_ptr_pre got=%0d exp=3", dut.ptr); end
    step(4'b1001, 1'b0, 1'b0);
    checks++;
    if (src_ready !== 4'b1001) begin failures++; $display("FAIL wrap_ready got=%b exp=1001", src_ready); end
    tick();
    checks++;
    if (cdb_valid !== 2'b11 || cdb_src !== 4'b0011 || {cdb_tag, cdb_data} !== {tags[0], tags[3], dat[0], dat[3]}) begin
      failures++; $display("FAIL wrap_bcast got v=%b s=%h t=%h d=%h exp v=11 s=3 t=%h d=%h",
                           cdb_valid, cdb_src, cdb_tag, cdb_data, {tags[0], tags[3]}, {dat[0], dat[3]});
    end
    checks++;
    if (dut.ptr !== 2'd1) begin failures++; $display("FAIL wrap_ptr got=%0d exp=1", dut.ptr); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < NS; i++) begin tags[i] = TW'($urandom); dat[i] = $urandom; end
    step(4'b1111, 1'b1, 1'b0);
    checks++;
    if (src_ready !== 4'b0000) begin failures++; $display("FAIL flush_ready got=%b exp=0000", src_ready); end
    // broadcast from the wrap grant is still visible during the flush cycle
    checks++;
    if (cdb_valid !== 2'b11) begin failures++; $display("FAIL flush_prev_visible got=%b exp=11", cdb_valid); end
    tick();
    checks++;
    if ({cdb_valid, cdb_src, cdb_tag, cdb_data} !== '0) begin
      failures++; $display("FAIL flush_outputs got=%h exp=0", {cdb_valid, cdb_src, cdb_tag, cdb_data});
    end
    checks++;
    if (dut.ptr !== 2'd1) begin failures++; $display("FAIL flush_ptr got=%0d exp=1", dut.ptr); end
    step(4'b1111, 1'b0, 1'b0);
    checks++;
    if (src_ready !== 4'b0110) begin failures++; $display("FAIL flush_resume_ready got=%b exp=0110", src_ready); end
    tick();
    checks++;
    if ({cdb_valid, cdb_src, cdb_tag, cdb_data} !== {e_valid, e_src, e_tag, e_data}) begin
      failures++; $display("FAIL flush_resume_bcast got=%h exp=%h", {cdb_valid, cdb_src, cdb_tag, cdb_data}, {e_valid, e_src, e_tag, e_data});
    end
  endtask

  task automatic test_idle_and_reset();
    for (int c = 0; c < 3; c++) begin
      step(4'b0000, 1'b0, 1'b0);
      checks++;
      if (src_ready !== 4'b0000) begin failures++; $display("FAIL idle_ready got=%b exp=0000", src_ready); end
      tick();
      checks++;
      if (cdb_valid !== 2'b00 || dut.ptr !== 2'd3) begin
        failures++; $display("FAIL idle_state got v=%b ptr=%0d exp v=00 ptr=3", cdb_valid, dut.ptr);
      end
    end
    step(4'b0110, 1'b0, 1'b1);
    checks++;
    if (src_ready !== 4'b0000) begin failures++; $display("FAIL midrst_ready got=%b exp=0000", src_ready); end
    tick();
    checks++;
    if ({cdb_valid, cdb_src, cdb_tag, cdb_data} !== '0 || dut.ptr !== 2'd0) begin
      failures++; $display("FAIL midrst_state got=%h ptr=%0d exp=0 ptr=0", {cdb_valid, cdb_src, cdb_tag, cdb_data}, dut.ptr);
    end
    step(4'b0110, 1'b0, 1'b0);
    checks++;
    if (src_ready !== 4'b0110) begin failures++; $display("FAIL midrst_rearb got=%b exp=0110", src_ready); end
    tick();
  endtask

`ifdef CDB_STALL_STATS_EN
  task automatic test_stall();
    step(4'b0000, 1'b0, 1'b1);
    tick();
    checks++;
    if (stall_cnt !== 32'd0) begin failures++; $display("FAIL stall_reset got=%0d exp=0", stall_cnt); end
    step(4'b1111, 1'b0, 1'b0);
    tick();
    checks++;
    if (stall_cnt !== 32'd2) begin failures++; $display("FAIL stall_c1 got=%0d exp=2", stall_cnt); end
    step(4'b1111, 1'b0, 1'b0);
    tick();
    checks++;
    if (stall_cnt !== 32'd4) begin failures++; $display("FAIL stall_c2 got=%0d exp=4", stall_cnt); end
    step(4'b1111, 1'b1, 1'b0);
    tick();
    checks++;
    if (stall_cnt !== 32'd4) begin failures++; $display("FAIL stall_flush got=%0d exp=4", stall_cnt); end
  endtask
`endif

  task automatic test_random();
    logic [NS-1:0] pend;
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NS; i++) begin
        if (!pend[i] && ($urandom_range(0, 9) < 6)) begin
          pend[i] = 1'b1; tags[i] = TW'($urandom); dat[i] = $urandom;
        end
      end
      step(pend, ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) == 0));
      checks++;
      if (src_ready !== m_ready) begin
        failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, src_ready, m_ready);
      end
      tick();
      checks++;
      if ({cdb_valid, cdb_src, cdb_tag, cdb_data} !== {e_valid, e_src, e_tag, e_data}) begin
        failures++; $display("FAIL rand_bcast cyc=%0d got=%h exp=%h", c, {cdb_valid, cdb_src, cdb_tag, cdb_data}, {e_valid, e_src, e_tag, e_data});
      end
`ifdef CDB_STALL_STATS_EN
      checks++;
      if (stall_cnt !== 32'(e_stall)) begin
        failures++; $display("FAIL rand_stall cyc=%0d got=%0d exp=%0d", c, stall_cnt, e_stall);
      end
`endif
      pend = pend & ~m_ready;
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; src_valid = '0; src_tag = '0; src_data = '0;
    m_ptr = 0; e_stall = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_flush();
    test_idle_and_reset();
`ifdef CDB_STALL_STATS_EN
    test_stall();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
